// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter/receiver pair.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int N_MIN     = 2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Divisors below N_MIN cannot centre-sample, so they are clamped up.
    function automatic logic [15:0] eff_n(input logic [15:0] n);
        return (n < 16'(N_MIN)) ? 16'(N_MIN) : n;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counter that times one bit (or half bit); tick is high while the count is zero.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        tick,
    output logic        pre_tick
);

    logic [15:0] cnt_d, cnt_q;

    // A load of V makes tick rise in the V-th cycle after the load edge.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val - 16'd1;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = (cnt_q == 16'd0);
    assign pre_tick = (cnt_q == 16'd1);

endmodule

// File: rtl/uart_txrx.sv
// 8N1 UART: independent transmit and receive paths sharing one baud divisor.
module uart_txrx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  write_buffer,
    input  logic [15:0] uart_baud_control,
    input  logic        send,
    output logic        tx_line,
    output logic        busy,
    input  logic        rx_line,
    output logic [7:0]  read_data,
    output logic        data_valid,
    output logic        frame_error
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    logic [15:0] baud_eff;
    assign baud_eff = eff_n(uart_baud_control);

    tx_state_t            tx_state_d, tx_state_q;
    logic [DATA_BITS-1:0] tx_shift_d, tx_shift_q;
    logic [IDX_W-1:0]     tx_idx_d, tx_idx_q;
    logic [15:0]          tx_n_d, tx_n_q;
    logic                 tx_d, tx_q;
    logic                 busy_d, busy_q;
    logic                 tx_load, tx_tick, tx_pre_tick;
    logic [15:0]          tx_load_val;
    logic                 accept;

    uart_bit_timer u_tx_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tx_load),
        .load_val (tx_load_val),
        .tick     (tx_tick),
        .pre_tick (tx_pre_tick)
    );

    // A new send is taken from IDLE or in the last stop cycle, which gives gapless frames.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_idx_d    = tx_idx_q;
        tx_n_d      = tx_n_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        tx_load     = 1'b0;
        tx_load_val = tx_n_q;
        accept      = send && ((tx_state_q == TX_IDLE) ||
                               (tx_state_q == TX_STOP && tx_tick));
        case (tx_state_q)
            TX_START: begin
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_idx_d   = '0;
                    tx_load    = 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_load = 1'b1;
                    if (tx_idx_q == LAST_BIT) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_idx_d   = tx_idx_q + IDX_W'(1);
                    end
                end
            end
            TX_STOP: begin
                // busy drops one cycle early so a host can queue the next byte.
                if (tx_pre_tick) begin
                    busy_d = 1'b0;
                end
                if (tx_tick) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
        if (accept) begin
            tx_state_d  = TX_START;
            tx_shift_d  = write_buffer;
            tx_n_d      = baud_eff;
            tx_d        = 1'b0;
            busy_d      = 1'b1;
            tx_load     = 1'b1;
            tx_load_val = baud_eff;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            tx_n_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_idx_q   <= tx_idx_d;
            tx_n_q     <= tx_n_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_line = tx_q;
    assign busy    = busy_q;

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic                   rx_s;
    rx_state_t              rx_state_d, rx_state_q;
    logic [DATA_BITS-1:0]   rx_shift_d, rx_shift_q;
    logic [IDX_W-1:0]       rx_idx_d, rx_idx_q;
    logic [15:0]            rx_n_d, rx_n_q;
    logic [7:0]             read_data_d, read_data_q;
    logic                   data_valid_d, data_valid_q;
    logic                   frame_error_d, frame_error_q;
    logic                   rx_load, rx_tick, rx_pre_tick_unused;
    logic [15:0]            rx_load_val;

    uart_bit_timer u_rx_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (rx_load),
        .load_val (rx_load_val),
        .tick     (rx_tick),
        .pre_tick (rx_pre_tick_unused)
    );

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_line};
    assign rx_s   = sync_q[SYNC_STAGES-1];

    // The half-bit wait in START puts every later sample near the bit centre.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_shift_d    = rx_shift_q;
        rx_idx_d      = rx_idx_q;
        rx_n_d        = rx_n_q;
        read_data_d   = read_data_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        rx_load       = 1'b0;
        rx_load_val   = rx_n_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d  = RX_START;
                    rx_n_d      = baud_eff;
                    rx_load     = 1'b1;
                    rx_load_val = baud_eff >> 1;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_idx_d   = '0;
                        rx_load    = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    rx_load    = 1'b1;
                    if (rx_idx_q == LAST_BIT) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + IDX_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (rx_s) begin
                        read_data_d  = rx_shift_q;
                        data_valid_d = 1'b1;
                        rx_state_d   = RX_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        rx_state_d    = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q        <= '1;
            rx_state_q    <= RX_IDLE;
            rx_shift_q    <= '0;
            rx_idx_q      <= '0;
            rx_n_q        <= '0;
            read_data_q   <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            rx_state_q    <= rx_state_d;
            rx_shift_q    <= rx_shift_d;
            rx_idx_q      <= rx_idx_d;
            rx_n_q        <= rx_n_d;
            read_data_q   <= read_data_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign read_data   = read_data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: loopback frames, back-to-back sends, framing errors, glitches, reset.
module tb_uart_txrx;

    logic        clk;
    logic        reset;
    logic [7:0]  write_buffer;
    logic [15:0] baud;
    logic        send;
    logic        tx_line;
    logic        busy;
    logic        rx_line;
    logic [7:0]  read_data;
    logic        data_valid;
    logic        frame_error;

    logic        loop;
    logic        rx_drv;

    int n_checks = 0;
    int n_fail   = 0;
    int dv_cnt   = 0;
    int fe_cnt   = 0;
    int dv0, fe0, busy_cycles, dvs, dv_at, k;
    logic [9:0] exp_frame;
    logic [7:0] bytes [5];

    assign rx_line = loop ? tx_line : rx_drv;

    uart_txrx #(.SYNC_STAGES(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .write_buffer      (write_buffer),
        .uart_baud_control (baud),
        .send              (send),
        .tx_line           (tx_line),
        .busy              (busy),
        .rx_line           (rx_line),
        .read_data         (read_data),
        .data_valid        (data_valid),
        .frame_error       (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid === 1'b1) dv_cnt++;
        if (frame_error === 1'b1) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (8) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        reset        = 1'b0;
        write_buffer = 8'h00;
        baud         = 16'd8;
        send         = 1'b0;
        loop         = 1'b1;
        rx_drv       = 1'b1;
        bytes        = '{8'hAA, 8'hF0, 8'h0F, 8'hCC, 8'hEE};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_line", tx_line, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_read_data", read_data, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single 0xAA loopback frame, N=8
        exp_frame    = 10'b1101010100;
        write_buffer = 8'hAA;
        send         = 1'b1;
        busy_cycles  = 0;
        dvs          = 0;
        dv_at        = -1;
        dv0          = dv_cnt;
        fe0          = fe_cnt;
        @(posedge clk);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) begin
                send = 1'b0;
                check("aa_busy_at_e0", busy, 1'b1);
            end
            if (busy) busy_cycles++;
            if (data_valid) begin
                dvs++;
                dv_at = c;
            end
            if (c < 80 && (c % 8) == 4) check("aa_tx_bit", tx_line, exp_frame[c / 8]);
        end
        check("aa_busy_cycles", busy_cycles, 79);
        check("aa_dv_pulses", dvs, 1);
        check("aa_dv_window", (dv_at >= 76 && dv_at <= 80), 1'b1);
        check("aa_read_data", read_data, 8'hAA);
        check("aa_no_fe", fe_cnt - fe0, 0);

        // Five back-to-back frames
        write_buffer = bytes[0];
        send         = 1'b1;
        k            = 0;
        fe0          = fe_cnt;
        @(posedge clk);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            send = 1'b0;
            if (c < 400 && (c % 80) == 0) begin
                check("b2b_start_busy", busy, 1'b1);
                check("b2b_start_tx", tx_line, 1'b0);
            end
            if (c == 79) check("b2b_last_stop_busy", busy, 1'b0);
            if (data_valid) begin
                if (k < 5) check("b2b_byte", read_data, bytes[k]);
                k++;
            end
            if (c < 320 && (c % 80) == 79) begin
                write_buffer = bytes[c / 80 + 1];
                send         = 1'b1;
            end
        end
        check("b2b_dv_count", k, 5);
        check("b2b_no_fe", fe_cnt - fe0, 0);

        // Send while busy is ignored
        exp_frame    = 10'b1010101010;
        write_buffer = 8'h55;
        send         = 1'b1;
        dv0          = dv_cnt;
        @(posedge clk);
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (c == 0 || c == 21) send = 1'b0;
            if (c == 20) begin
                write_buffer = 8'h12;
                send         = 1'b1;
            end
            if (c < 80 && (c % 8) == 4) check("ign_tx_bit", tx_line, exp_frame[c / 8]);
            if (c == 100) begin
                check("ign_idle_busy", busy, 1'b0);
                check("ign_idle_tx", tx_line, 1'b1);
            end
        end
        check("ign_dv_count", dv_cnt - dv0, 1);
        check("ign_read_data", read_data, 8'h55);

        // Framing error on directly driven RX, line held low afterwards
        loop   = 1'b0;
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        drive_rx_frame(8'h3C, 1'b0);
        repeat (100) @(negedge clk);
        check("fe_pulse_count", fe_cnt - fe0, 1);
        check("fe_no_dv", dv_cnt - dv0, 0);
        check("fe_read_data_kept", read_data, 8'h55);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        drive_rx_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        check("fe_recover_dv", dv_cnt - dv0, 1);
        check("fe_recover_data", read_data, 8'hA5);
        check("fe_recover_no_new_fe", fe_cnt - fe0, 1);

        // 3-cycle glitch is rejected
        dv0    = dv_cnt;
        fe0    = fe_cnt;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_dv", dv_cnt - dv0, 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        drive_rx_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        check("glitch_next_dv", dv_cnt - dv0, 1);
        check("glitch_next_data", read_data, 8'h81);

        // Divisor 0 is treated as 2
        loop         = 1'b1;
        baud         = 16'd0;
        write_buffer = 8'h5A;
        send         = 1'b1;
        busy_cycles  = 0;
        dv0          = dv_cnt;
        @(posedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            send = 1'b0;
            if (busy) busy_cycles++;
            if (c == 1) check("n0_tx_start", tx_line, 1'b0);
            if (c == 2) check("n0_tx_bit0", tx_line, 1'b0);
            if (c == 4) check("n0_tx_bit1", tx_line, 1'b1);
        end
        check("n0_busy_cycles", busy_cycles, 19);
        check("n0_dv_count", dv_cnt - dv0, 1);
        check("n0_read_data", read_data, 8'h5A);

        // Reset mid-frame
        baud         = 16'd8;
        write_buffer = 8'h3C;
        send         = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            send = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("mid_rst_tx_line", tx_line, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_read_data", read_data, 8'h00);
        check("mid_rst_dv", data_valid, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        dv0   = dv_cnt;
        fe0   = fe_cnt;
        repeat (120) @(negedge clk);
        check("post_rst_no_dv", dv_cnt - dv0, 0);
        check("post_rst_no_fe", fe_cnt - fe0, 0);
        check("post_rst_tx_idle", tx_line, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_txrx.md
UART_TXRX -- requirements
Module: uart_txrx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops synchronising rx_line (legal range 2..3).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port write_buffer, input, 8 bits: byte to transmit, captured on send acceptance.
REQ-005 SHALL have port uart_baud_control, input, 16 bits: N, the clk cycles per bit, shared by TX and RX.
REQ-006 SHALL have port send, input, 1 bit: transmit request, sampled each clk edge.
REQ-007 SHALL have port tx_line, output, 1 bit: serial TX line, registered, idle high.
REQ-008 SHALL have port busy, output, 1 bit: TX frame in progress.
REQ-009 SHALL have port rx_line, input, 1 bit: asynchronous serial RX line, idle high.
REQ-010 SHALL have port read_data, output, 8 bits: last correctly framed received byte.
REQ-011 SHALL have port data_valid, output, 1 bit: 1-cycle pulse when read_data updates.
REQ-012 SHALL have port frame_error, output, 1 bit: 1-cycle pulse when a stop bit samples 0.

Function
REQ-013 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity; 10N cycles per frame.
REQ-014 Effective N SHALL be uart_baud_control, with values 0 or 1 treated as 2; each path SHALL latch N at frame start, so changes mid-frame have no effect.
REQ-015 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 TX SHALL accept send=1 in IDLE, or in the final cycle of STOP (back-to-back, no idle gap); at accept edge E0 it SHALL capture write_buffer and drive tx_line=0.
REQ-017 TX SHALL hold start for cycles E0..E0+N-1, data bit i for E0+(i+1)N..E0+(i+2)N-1, and stop (1) for E0+9N..E0+10N-1, then return to IDLE unless a new send is accepted.
REQ-018 busy SHALL be 1 from edge E0 through every non-IDLE cycle, except 0 in the final STOP cycle.
REQ-019 send while busy=1 SHALL be ignored; changes to write_buffer after E0 SHALL NOT affect the frame.
REQ-020 RX SHALL pass rx_line through SYNC_STAGES flops before any use.
REQ-021 RX FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-022 In IDLE, a synced 0 SHALL enter START; after floor(N/2) cycles the line SHALL be re-sampled, returning to IDLE if 1 (glitch rejection).
REQ-023 Otherwise RX SHALL sample 8 data bits every N cycles into a shift register, LSB first, then sample the stop bit N cycles later.
REQ-024 If the stop bit is 1, RX SHALL load read_data and pulse data_valid for one cycle, then go to IDLE.
REQ-025 If the stop bit is 0, RX SHALL pulse frame_error, keep read_data unchanged, and go to WAIT_HIGH until the synced line is 1.
REQ-026 data_valid SHALL assert no earlier than E0+9N+floor(N/2) and no later than E0+9N+floor(N/2)+SYNC_STAGES+2 when tx_line loops to rx_line.
REQ-027 TX and RX SHALL be fully independent; simultaneous operation SHALL NOT interact.

Reset
REQ-028 reset=0 SHALL asynchronously force tx_line=1, busy=0, read_data=0x00, data_valid=0, frame_error=0, both FSMs to IDLE, synchroniser flops to 1, and counters to 0.
REQ-029 Reset mid-frame SHALL abort both paths immediately; no partial byte SHALL be reported after release.

Structure
REQ-030 Package uart_pkg SHALL hold the TX/RX state typedefs, DATA_BITS=8, and N_MIN=2.
REQ-031 One sub-module, uart_bit_timer (16-bit down-counter: load N or floor(N/2), tick on expiry), SHALL be instantiated once per path.

Verification
REQ-032 N=8, tx_line looped to rx_line, send 0xAA pulse -> tx_line 0,0,1,0,1,0,1,0,1,1 per 8-cycle bit; busy high 79 cycles; read_data=0xAA with one data_valid pulse.
REQ-033 Loopback, sends every 80 cycles of 0xAA, 0xF0, 0x0F, 0xCC, 0xEE -> all five accepted back-to-back; five data_valid pulses in order; no frame_error.
REQ-034 send 0x55 accepted, then send 0x12 at E0+20 -> ignored; tx_line carries only 0x55.
REQ-035 Drive rx_line directly with stop bit 0 -> frame_error pulse, read_data unchanged; RX waits for line high before the next frame.
REQ-036 rx_line low pulse of 3 cycles with N=8 -> no data_valid, no frame_error, RX back in IDLE.
REQ-037 Assert reset mid-frame at E0+35 -> tx_line=1, busy=0 immediately; no data_valid after release.
